serial_add_ctrl: RTL and testbench

- Multi-word add/subtract sequencer. Computes a WIDTH-bit result by time-multiplexing one 4-bit ripple adder slice, least-significant nibble first, and chains the carry through a register between cycles.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Lets wide additions reuse the team's 4-bit adder slice instead of instantiating a full-width adder.

---
 rtl/serial_add_pkg.sv | 17 +
 rtl/add4_slice.sv | 26 ++
 rtl/serial_add_ctrl.sv | 112 +++++++++++
 tb/tb_serial_add_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the nibble-serial add/subtract sequencer.
package serial_add_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble counter; never narrower than one bit.
    function automatic int cnt_width(input int nslice);
        return (nslice <= 1) ? 1 : $clog2(nslice);
    endfunction

endpackage

// File: rtl/add4_slice.sv
// Purely combinational 4-bit ripple-carry adder slice.
module add4_slice
    import serial_add_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [SLICE_W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < SLICE_W; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
        end
    end

    assign co = c[SLICE_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// WIDTH-bit add/subtract computed one nibble per cycle through a shared 4-bit slice,
// LS nibble first, with valid/ready handshakes on operand and result sides.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CW     = cnt_width(NSLICE);

    state_t                    state_q, state_d;
    logic [WIDTH-1:0]          a_q, a_d;
    logic [WIDTH-1:0]          b_q, b_d;
    logic [WIDTH-1:0]          res_q, res_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      carry_q, carry_d;
    logic                      cout_q, cout_d;

    logic [SLICE_W-1:0]        slice_s;
    logic                      slice_co;
    logic [WIDTH+SLICE_W-1:0]  res_cat;
    logic                      accept;
    logic                      last_nib;

    add4_slice u_slice (
        .x  (a_q[SLICE_W-1:0]),
        .y  (b_q[SLICE_W-1:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    assign accept   = (state_q == IDLE) && in_valid;
    assign last_nib = (cnt_q == CW'(NSLICE - 1));
    assign res_cat  = {slice_s, res_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_nib)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Datapath next-state: subtraction is a + ~b + 1, folded in at capture.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        if (accept) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub ? 1'b1 : cin;
            cnt_d   = '0;
            res_d   = '0;
        end else if (state_q == RUN) begin
            a_d     = a_q >> SLICE_W;
            b_d     = b_q >> SLICE_W;
            res_d   = res_cat[WIDTH+SLICE_W-1:SLICE_W];
            carry_d = slice_co;
            cnt_d   = cnt_q + CW'(1);
            if (last_nib) cout_d = slice_co;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = res_q;
        cout      = cout_q;
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: driver pushes expected results, monitor checks them.
module tb_serial_add_ctrl;

    localparam int W  = 16;
    localparam int NS = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;

    typedef struct {
        logic [W:0] res;
        int         acc;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       prev_valid = 1'b0;
    logic [W:0] held = '0;
    logic       force_mode = 1'b1;
    logic       fval = 1'b1;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci, input logic s);
        logic [W-1:0] ny;
        ny = ~y;
        if (s) return {1'b0, x} + {1'b0, ny} + (W+1)'(1);
        return {1'b0, x} + {1'b0, y} + (W+1)'(ci);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Consumer: out_ready either forced by the sequence or randomly throttled.
    always begin
        @(negedge clk);
        #1;
        out_ready = force_mode ? fval : ($urandom_range(0, 3) != 0);
    end

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sum", 32'(sum), 32'(e.res[W-1:0]));
                    check("cout", 32'(cout), 32'(e.res[W]));
                    check("latency", 32'(cyc - e.acc), 32'(NS));
                    held = {cout, sum};
                end
            end else if (out_valid && prev_valid) begin
                check("hold_result", 32'({cout, sum}), 32'(held));
            end
            if (out_valid) check("in_ready_busy", 32'(in_ready), 32'd0);
        end
        prev_valid = rst ? 1'b0 : out_valid;
    end

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic icin, input logic isub);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        a = ia; b = ib; cin = icin; sub = isub;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        e.res = ref_model(ia, ib, icin, isub);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        @(negedge clk);
        while ((sb.size() != 0 || out_valid) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0 || out_valid) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ra, rb;
        int           guard;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;

        // Directed arithmetic
        force_mode = 1'b1; fval = 1'b1;
        issue(16'h1234, 16'h0FED, 1'b0, 1'b0);
        wait_drain();
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_drain();
        issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        wait_drain();
        issue(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_drain();
        issue(16'h0007, 16'h0005, 1'b1, 1'b1);
        wait_drain();

        // Input stability: operands scrambled every cycle during RUN
        issue(16'hA5C3, 16'h3C5A, 1'b1, 1'b0);
        repeat (NS) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
        end
        wait_drain();

        // Backpressure with in_valid held high during DONE
        fval = 1'b0;
        issue(16'h8001, 16'h7FFF, 1'b0, 1'b1);
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("bp_reach_done", 32'(out_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        fval = 1'b1;
        in_valid = 1'b1;
        ra = 16'h4321; rb = 16'h1111;
        a = ra; b = rb; cin = 1'b1; sub = 1'b0;
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        begin
            exp_t e;
            e.res = ref_model(ra, rb, 1'b1, 1'b0);
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();

        // Reset mid-operation
        issue(16'h1234, 16'h0FED, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        issue(16'h1234, 16'h0FED, 1'b0, 1'b0);
        wait_drain();

        // Randomized traffic with throttled consumer
        force_mode = 1'b0;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       ra = 16'hFFFF;
                1:       ra = 16'h0000;
                default: ra = 16'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 16'hFFFF;
                1:       rb = 16'h0000;
                default: rb = 16'($urandom);
            endcase
            issue(ra, rb, 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        force_mode = 1'b1; fval = 1'b1;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
